// File: rtl/ccd_line2axis.sv
// CCD line receiver: frames sensor lines, strips dummy columns and emits
// effective pixels as AXI4-Stream video through a first-word-fall-through FIFO.
module ccd_line2axis #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAPS       = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                           pixel_clk,
  input  logic                           rst,
  input  logic [12:0]                    cfg_pre_cols,
  input  logic [12:0]                    cfg_eff_cols,
  input  logic [12:0]                    cfg_post_cols,
  input  logic [11:0]                    cfg_rows,
  input  logic                           err_clr,
  input  logic                           s_tvalid,
  input  logic [TAPS*DATA_WIDTH-1:0]     s_tdata,
  output logic [TAPS*DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic [11:0]                    row_cnt,
  output logic                           ovf_err,
  output logic                           short_err
);

  localparam int unsigned W  = TAPS * DATA_WIDTH;
  localparam int unsigned FW = W + 2;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_EFF, ST_POST} state_t;

  state_t          r_state, w_state_nxt, w_act_state;
  logic            r_s1_valid, r_s1_valid_d, r_armed;
  logic [W-1:0]    r_s1_data;
  logic [12:0]     r_pre, r_eff, r_post, r_col;
  logic [12:0]     w_pre, w_eff, w_post, w_cnt, w_act_col, w_col_nxt;
  logic            w_line_start, w_last, w_wr_req, w_short;
  logic            w_tuser, w_tlast;
  logic [11:0]     w_row_nxt, w_row;
  logic [FW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic            w_empty, w_full, w_pop, w_push, w_ovf;
  logic [FW-1:0]   w_head;

  // A line starts on a fresh rising edge of the registered valid; r_armed
  // blocks a line that was already in progress when reset was released.
  assign w_line_start = (r_state == ST_IDLE) && r_s1_valid && !r_s1_valid_d && r_armed;
  assign w_row_nxt    = ((row_cnt >= cfg_rows) || (row_cnt == 12'd0)) ? 12'd1 : row_cnt + 12'd1;
  assign w_row        = w_line_start ? w_row_nxt : row_cnt;

  // Input stage S1, previous-valid history and re-arm tracking
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_valid_d <= 1'b0;
      r_s1_data    <= '0;
      r_armed      <= 1'b0;
    end else begin
      r_s1_valid   <= s_tvalid;
      r_s1_valid_d <= r_s1_valid;
      r_s1_data    <= s_tdata;
      r_armed      <= r_armed | ~s_tvalid;
    end
  end

  // Effective state/column/counts for this beat; the line-start beat is beat 0
  always_comb begin
    w_pre       = r_pre;
    w_eff       = r_eff;
    w_post      = r_post;
    w_act_state = r_state;
    w_act_col   = r_col;
    if (w_line_start) begin
      w_pre     = cfg_pre_cols;
      w_eff     = cfg_eff_cols;
      w_post    = cfg_post_cols;
      w_act_col = 13'd0;
      if (cfg_pre_cols != 13'd0)      w_act_state = ST_PRE;
      else if (cfg_eff_cols != 13'd0) w_act_state = ST_EFF;
      else                            w_act_state = ST_POST;
    end
  end

  // Next-state, column counter and FIFO write request
  always_comb begin
    w_state_nxt = w_act_state;
    w_col_nxt   = w_act_col;
    w_wr_req    = 1'b0;
    w_short     = 1'b0;
    case (w_act_state)
      ST_PRE:  w_cnt = w_pre;
      ST_EFF:  w_cnt = w_eff;
      ST_POST: w_cnt = w_post;
      default: w_cnt = 13'd0;
    endcase
    w_last  = (14'(w_act_col) + 14'd1) >= 14'(w_cnt);
    w_tuser = (w_row == 12'd1) && (w_act_col == 13'd0);
    w_tlast = (14'(w_act_col) + 14'd1) == 14'(w_eff);
    if ((r_state != ST_IDLE) && !r_s1_valid) begin
      w_short     = 1'b1;
      w_state_nxt = ST_IDLE;
      w_col_nxt   = 13'd0;
    end else begin
      case (w_act_state)
        ST_PRE: begin
          if (w_last) begin
            w_col_nxt = 13'd0;
            if (w_eff != 13'd0)       w_state_nxt = ST_EFF;
            else if (w_post != 13'd0) w_state_nxt = ST_POST;
            else                      w_state_nxt = ST_IDLE;
          end else begin
            w_col_nxt = w_act_col + 13'd1;
          end
        end
        ST_EFF: begin
          w_wr_req = 1'b1;
          if (w_last) begin
            w_col_nxt   = 13'd0;
            w_state_nxt = (w_post != 13'd0) ? ST_POST : ST_IDLE;
          end else begin
            w_col_nxt = w_act_col + 13'd1;
          end
        end
        ST_POST: begin
          if (w_last) begin
            w_col_nxt   = 13'd0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_col_nxt = w_act_col + 13'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_col_nxt   = 13'd0;
        end
      endcase
    end
  end

  // State, column, latched config and row counter
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_col   <= 13'd0;
      r_pre   <= 13'd0;
      r_eff   <= 13'd0;
      r_post  <= 13'd0;
      row_cnt <= 12'd0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_pre   <= w_pre;
      r_eff   <= w_eff;
      r_post  <= w_post;
      if (w_line_start) row_cnt <= w_row_nxt;
    end
  end

  // FIFO status; a pop frees the slot a simultaneous push needs when full
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && m_axis_tready;
  assign w_push  = w_wr_req && (!w_full || w_pop);
  assign w_ovf   = w_wr_req && w_full && !w_pop;

  // FIFO storage
  always_ff @(posedge pixel_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_tuser, w_tlast, r_s1_data};
  end

  // FIFO pointers
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      ovf_err   <= 1'b0;
      short_err <= 1'b0;
    end else begin
      if (w_ovf)        ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
      if (w_short)      short_err <= 1'b1;
      else if (err_clr) short_err <= 1'b0;
    end
  end

  // FWFT head word, forced to zero while empty
  assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0   : w_head[W-1:0];
  assign m_axis_tlast  = w_empty ? 1'b0 : w_head[W];
  assign m_axis_tuser  = w_empty ? 1'b0 : w_head[W+1];

endmodule

// File: tb/tb_ccd_line2axis.sv
// Scoreboard bench for ccd_line2axis: directed lines push expected beats,
// a monitor pops and compares on every output handshake.
module tb_ccd_line2axis;

  logic        pixel_clk;
  logic        rst;
  logic [12:0] cfg_pre_cols, cfg_eff_cols, cfg_post_cols;
  logic [11:0] cfg_rows;
  logic        err_clr;
  logic        s_tvalid;
  logic [7:0]  s_tdata;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [11:0] row_cnt;
  logic        ovf_err, short_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [9:0]  q[$];

  ccd_line2axis #(.DATA_WIDTH(8), .TAPS(1), .FIFO_DEPTH(16)) dut (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .cfg_pre_cols  (cfg_pre_cols),
    .cfg_eff_cols  (cfg_eff_cols),
    .cfg_post_cols (cfg_post_cols),
    .cfg_rows      (cfg_rows),
    .err_clr       (err_clr),
    .s_tvalid      (s_tvalid),
    .s_tdata       (s_tdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .row_cnt       (row_cnt),
    .ovf_err       (ovf_err),
    .short_err     (short_err)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted output beat against the scoreboard head
  always @(negedge pixel_clk) begin
    #1;
    if (m_axis_tvalid && m_axis_tready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got 0x%0h expected none at %0t",
                 {m_axis_tuser, m_axis_tlast, m_axis_tdata}, $time);
      end else begin
        logic [9:0] e;
        e = q.pop_front();
        chk("beat", {22'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'd0, e});
      end
    end
  end

  // Drive one line (cut < 0 means full length); only the first 'keep'
  // effective beats are expected to survive the FIFO.
  task automatic run_line(input int pre, input int eff, input int post, input int cut,
                          input int keep, input bit row1, input logic [7:0] seed,
                          input bit lat);
    int total;
    total = pre + eff + post;
    if (cut >= 0 && cut < total) total = cut;
    cfg_pre_cols  = 13'(pre);
    cfg_eff_cols  = 13'(eff);
    cfg_post_cols = 13'(post);
    for (int b = 0; b < total; b++) begin
      @(negedge pixel_clk);
      s_tvalid = 1'b1;
      s_tdata  = seed + 8'(b);
      if (b >= pre && b < pre + eff && (b - pre) < keep)
        q.push_back({row1 && (b == pre), (b - pre) == eff - 1, s_tdata});
      if (lat && b == 1) chk("latency_n1_tvalid", m_axis_tvalid, 0);
      if (lat && b == 2) begin
        chk("latency_n2_tvalid", m_axis_tvalid, 1);
        chk("latency_n2_tdata", m_axis_tdata, seed);
      end
    end
    @(negedge pixel_clk);
    s_tvalid = 1'b0;
    repeat (4) @(negedge pixel_clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_axis_tready = 1'b1;
    while (q.size() != 0 && n < 5000) begin
      @(negedge pixel_clk);
      n++;
    end
    repeat (3) @(negedge pixel_clk);
    chk("drain_left", q.size(), 0);
    chk("drain_tvalid", m_axis_tvalid, 0);
  endtask

  task automatic pulse_clr();
    @(negedge pixel_clk);
    err_clr = 1'b1;
    @(negedge pixel_clk);
    err_clr = 1'b0;
    chk("clr_ovf", ovf_err, 0);
    chk("clr_short", short_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_axis_tready = 1'b1; err_clr = 1'b0;
    cfg_pre_cols = '0; cfg_eff_cols = '0; cfg_post_cols = '0; cfg_rows = 12'd3;
    repeat (3) @(negedge pixel_clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_row", row_cnt, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_short", short_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge pixel_clk);

    // Basic frame, rows=3, then wrap on the fourth line
    run_line(32, 2048, 8, -1, 9999, 1, 8'h00, 0); chk("frame_row1", row_cnt, 1);
    run_line(32, 2048, 8, -1, 9999, 0, 8'h40, 0); chk("frame_row2", row_cnt, 2);
    run_line(32, 2048, 8, -1, 9999, 0, 8'h80, 0); chk("frame_row3", row_cnt, 3);
    run_line(32, 2048, 8, -1, 9999, 1, 8'hc0, 0); chk("frame_row_wrap", row_cnt, 1);
    drain();

    // Zero pre: line-start beat is effective, two-clock latency
    run_line(0, 4, 2, -1, 9999, 0, 8'h11, 1); chk("zpre_row", row_cnt, 2);
    drain();

    // Backpressure with overflow: 16 kept, no tlast
    m_axis_tready = 1'b0;
    run_line(2, 40, 2, -1, 16, 0, 8'h20, 0);
    chk("bp_ovf", ovf_err, 1);
    chk("bp_row", row_cnt, 3);
    drain();
    pulse_clr();

    // Exactly FIFO_DEPTH beats: no overflow, tlast on the 16th
    m_axis_tready = 1'b0;
    run_line(2, 16, 2, -1, 16, 1, 8'h50, 0);
    chk("full_no_ovf", ovf_err, 0);
    chk("full_row", row_cnt, 1);
    drain();

    // Short line after eff beat 10, then a normal line
    run_line(32, 2048, 8, 43, 9999, 0, 8'h33, 0);
    chk("short_flag", short_err, 1);
    chk("short_row", row_cnt, 2);
    run_line(32, 2048, 8, -1, 9999, 0, 8'h77, 0);
    chk("after_short_row", row_cnt, 3);
    chk("after_short_ovf", ovf_err, 0);
    drain();
    pulse_clr();

    // Async reset in the middle of EFF with valid still high
    m_axis_tready = 1'b0;
    cfg_pre_cols = 13'd2; cfg_eff_cols = 13'd20; cfg_post_cols = 13'd2;
    for (int b = 0; b < 12; b++) begin
      @(negedge pixel_clk);
      s_tvalid = 1'b1;
      s_tdata  = 8'(b);
    end
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    #2 rst = 1'b1;
    #2;
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tdata", m_axis_tdata, 0);
    chk("midrst_row", row_cnt, 0);
    @(negedge pixel_clk);
    rst = 1'b0;
    repeat (6) @(negedge pixel_clk);
    s_tvalid = 1'b0;
    repeat (4) @(negedge pixel_clk);
    chk("rst_held_tvalid", m_axis_tvalid, 0);
    chk("rst_held_row", row_cnt, 0);
    m_axis_tready = 1'b1;
    run_line(1, 6, 1, -1, 9999, 1, 8'h90, 0);
    chk("post_rst_row", row_cnt, 1);
    drain();

    // Lowering cfg_rows below row_cnt wraps to row 1
    cfg_rows = 12'd5;
    run_line(1, 4, 1, -1, 9999, 0, 8'ha0, 0);
    run_line(1, 4, 1, -1, 9999, 0, 8'hb0, 0);
    run_line(1, 4, 1, -1, 9999, 0, 8'hc0, 0);
    chk("wrap_row4", row_cnt, 4);
    cfg_rows = 12'd2;
    run_line(1, 4, 1, -1, 9999, 1, 8'hd0, 0);
    chk("wrap_row1", row_cnt, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
